lives_manager: RTL and testbench
================================

// Module: lives_manager
// PURPOSE
//  Parametrised player-lives tracker for the game core; successor of the single-source HP counter.
//  Merges N damage sources and grants bonus lives with a saturating cap.
//  After each hit, applies a frame-timed invulnerability window.
//  Sequences ALIVE/INVULN/DEAD and flags game over to the game controller and the HUD/VGA overlay.
// PARAMETERS
//  LIVES_W        3   width of lives counter/output
//  INITIAL_LIVES  3   lives loaded on reset/new_game; 1..MAX_LIVES
//  MAX_LIVES      5   saturation cap for bonus lives; < 2**LIVES_W
//  N_SRC          2   number of damage sources (hit vector width), >=1
//  INVULN_FRAMES  60  frame_tick count of post-hit invulnerability, >=1
//  Parameter constraint violation -> elaboration error ($error in initial/generate).
// PORTS
//  clk         in   1        system clock
//  resetN      in   1        asynchronous, active-low reset
//  freeze_n    in   1        0 = game paused: state, timer, lives held
//  new_game    in   1        sync reload to reset values (1-cycle pulse)
//  hit         in   N_SRC    per-source collision pulses (pacman vs monster k)
//  bonus_life  in   1        1-cycle pulse: award one life
//  frame_tick  in   1        1-cycle pulse per video frame
//  lives       out  LIVES_W  current lives count
//  invuln      out  1        1 while in INVULN
//  life_lost   out  1        1-cycle pulse when a life is deducted
//  game_over   out  1        1 while in DEAD
// BEHAVIOUR
//  All outputs are registered. An input sampled at edge k is reflected in the outputs right after edge k.
//  Reset (async) and new_game (sync) have identical effect:
//   - state=ALIVE, lives=INITIAL_LIVES, timer=0.
//   - invuln=0, life_lost=0, game_over=0.
//  Priority: resetN > new_game > freeze_n=0 > normal operation.
//   - new_game acts even while frozen or DEAD.
//  freeze_n=0: no state/lives/timer change; life_lost forced 0; hit/bonus/tick dropped (not queued).
//  any_hit = |hit. Simultaneous hits from several sources count as ONE hit.
//  ALIVE:
//   - any_hit: next = lives-1, then +1 if bonus_life (saturate at MAX_LIVES); life_lost=1 for one cycle.
//   - If next==0 -> DEAD, game_over=1. Else -> INVULN, timer=INVULN_FRAMES, invuln=1.
//   - bonus_life only (no hit): lives=min(lives+1, MAX_LIVES); stay ALIVE.
//  INVULN:
//   - hit ignored; bonus_life applied as in ALIVE.
//   - frame_tick: timer-1. On frame_tick with timer==1 -> ALIVE, invuln=0 on the same edge.
//   - A hit on the cycle after returning to ALIVE is honoured.
//  DEAD:
//   - lives=0, game_over=1; hit, bonus_life, frame_tick ignored.
//   - Exit only via new_game or resetN.
//  Timer width $clog2(INVULN_FRAMES+1). Timer is unsigned and never wraps below 0.
//  lives never exceeds MAX_LIVES and never underflows.
//  resetN asserted mid-INVULN clears timer and invuln immediately (async).
// TESTING
//  1. Reset, defaults -> lives=3, invuln=0, game_over=0. hit=2'b01 one cycle -> lives=2, life_lost 1 cycle, invuln=1.
//  2. INVULN_FRAMES=4: after hit, further hits ignored -> lives stays 2. invuln falls on 4th frame_tick.
//     Next hit -> lives=1.
//  3. hit=2'b11 in one cycle at lives=3 -> lives=2 (single decrement).
//     Three separated hits (each after invuln expiry) -> lives=0, game_over=1; later hit/bonus ignored.
//  4. bonus_life x4 from lives=3 -> lives=5 (saturated). Hit+bonus same cycle at lives=1 -> lives=1, INVULN, life_lost=1.
//  5. freeze_n=0 during INVULN with 10 frame_ticks and hits -> lives/timer unchanged.
//     After release, invuln still expires after the remaining ticks.
//  6. new_game while DEAD and frozen -> lives=3, game_over=0 next cycle.
//     resetN low mid-INVULN -> invuln=0 without waiting for a clock edge.

Source files
------------

// File: rtl/lives_manager.sv
// Player-lives tracker: merges N hit sources, saturating bonus lives, frame-timed invulnerability, game over.
// Latency: inputs sampled at edge k appear on registered outputs after edge k; no backpressure, frozen inputs are dropped.
module lives_manager #(
  parameter int LIVES_W       = 3,
  parameter int INITIAL_LIVES = 3,
  parameter int MAX_LIVES     = 5,
  parameter int N_SRC         = 2,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               freeze_n,
  input  logic               new_game,
  input  logic [N_SRC-1:0]   hit,
  input  logic               bonus_life,
  input  logic               frame_tick,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               life_lost,
  output logic               game_over
);

  localparam int TMR_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [1:0] ST_ALIVE  = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INITIAL_LIVES);
  localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);
  localparam logic [TMR_W-1:0]   TMR_LD = TMR_W'(INVULN_FRAMES);

  generate
    if (LIVES_W < 1 || MAX_LIVES >= (1 << LIVES_W)) begin : g_bad_max
      $error("lives_manager: MAX_LIVES must be < 2**LIVES_W");
    end
    if (INITIAL_LIVES < 1 || INITIAL_LIVES > MAX_LIVES) begin : g_bad_init
      $error("lives_manager: INITIAL_LIVES must be in 1..MAX_LIVES");
    end
    if (N_SRC < 1) begin : g_bad_nsrc
      $error("lives_manager: N_SRC must be >= 1");
    end
    if (INVULN_FRAMES < 1) begin : g_bad_frames
      $error("lives_manager: INVULN_FRAMES must be >= 1");
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               life_lost_q, life_lost_d;
  logic               invuln_q, invuln_d;
  logic               game_over_q, game_over_d;

  logic               any_hit;
  logic [LIVES_W-1:0] lives_inc;
  logic [LIVES_W-1:0] lives_hit;

  assign any_hit   = |hit;
  assign lives_inc = (lives_q >= MAX_L) ? MAX_L : lives_q + LIVES_W'(1);

  // Hit and bonus in the same cycle: deduct first, then re-award under the cap.
  always_comb begin
    lives_hit = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
    if (bonus_life) begin
      lives_hit = (lives_hit >= MAX_L) ? MAX_L : lives_hit + LIVES_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    timer_d     = timer_q;
    life_lost_d = 1'b0;
    if (new_game) begin
      state_d = ST_ALIVE;
      lives_d = INIT_L;
      timer_d = '0;
    end else if (freeze_n) begin
      case (state_q)
        ST_ALIVE: begin
          if (any_hit) begin
            life_lost_d = 1'b1;
            lives_d     = lives_hit;
            if (lives_hit == '0) begin
              state_d = ST_DEAD;
              timer_d = '0;
            end else begin
              state_d = ST_INVULN;
              timer_d = TMR_LD;
            end
          end else if (bonus_life) begin
            lives_d = lives_inc;
          end
        end
        ST_INVULN: begin
          if (bonus_life) begin
            lives_d = lives_inc;
          end
          if (frame_tick) begin
            if (timer_q <= TMR_W'(1)) begin
              state_d = ST_ALIVE;
              timer_d = '0;
            end else begin
              timer_d = timer_q - TMR_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_DEAD;
          lives_d = '0;
          timer_d = '0;
        end
      endcase
    end
    invuln_d    = (state_d == ST_INVULN);
    game_over_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_ALIVE;
      lives_q     <= INIT_L;
      timer_q     <= '0;
      life_lost_q <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      life_lost_q <= life_lost_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign lives     = lives_q;
  assign invuln    = invuln_q;
  assign life_lost = life_lost_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager with INVULN_FRAMES=4 and hand-computed expectations.
module tb_lives_manager;

  logic       clk;
  logic       resetN;
  logic       freeze_n;
  logic       new_game;
  logic [1:0] hit;
  logic       bonus_life;
  logic       frame_tick;
  logic [2:0] lives;
  logic       invuln;
  logic       life_lost;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;

  lives_manager #(
    .LIVES_W(3), .INITIAL_LIVES(3), .MAX_LIVES(5), .N_SRC(2), .INVULN_FRAMES(4)
  ) dut (
    .clk(clk), .resetN(resetN), .freeze_n(freeze_n), .new_game(new_game),
    .hit(hit), .bonus_life(bonus_life), .frame_tick(frame_tick),
    .lives(lives), .invuln(invuln), .life_lost(life_lost), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic hit_once(input logic [1:0] h);
    hit = h;
    step();
    hit = 2'b00;
  endtask

  task automatic chk_all(input string tag, input int l, input int inv, input int ll, input int go);
    check({tag, ".lives"}, int'(lives), l);
    check({tag, ".invuln"}, int'(invuln), inv);
    check({tag, ".life_lost"}, int'(life_lost), ll);
    check({tag, ".game_over"}, int'(game_over), go);
  endtask

  initial begin
    resetN = 1'b0; freeze_n = 1'b1; new_game = 1'b0;
    hit = 2'b00; bonus_life = 1'b0; frame_tick = 1'b0;
    #12;
    chk_all("reset", 3, 0, 0, 0);
    resetN = 1'b1;
    step();
    chk_all("idle", 3, 0, 0, 0);

    // Single hit from source 0
    hit_once(2'b01);
    chk_all("hit1", 2, 1, 1, 0);
    step();
    check("hit1.pulse_end", int'(life_lost), 0);

    // Hits ignored while invulnerable; window lasts 4 ticks
    hit_once(2'b11);
    chk_all("inv_hit", 2, 1, 0, 0);
    tick_n(3);
    check("tick3.invuln", int'(invuln), 1);
    tick_n(1);
    check("tick4.invuln", int'(invuln), 0);
    hit_once(2'b10);
    chk_all("hit_after_exp", 1, 1, 1, 0);

    // Hit+bonus at lives=1 keeps the life and enters INVULN
    tick_n(4);
    hit = 2'b01; bonus_life = 1'b1;
    step();
    hit = 2'b00; bonus_life = 1'b0;
    chk_all("hit_bonus", 1, 1, 1, 0);

    // Freeze mid-window: one tick consumed, then 10 frozen ticks with hits and bonus
    tick_n(1);
    freeze_n = 1'b0;
    hit = 2'b11; frame_tick = 1'b1; bonus_life = 1'b1;
    for (int i = 0; i < 10; i++) step();
    hit = 2'b00; frame_tick = 1'b0; bonus_life = 1'b0;
    chk_all("frozen", 1, 1, 0, 0);
    freeze_n = 1'b1;
    step();
    tick_n(2);
    check("resume2.invuln", int'(invuln), 1);
    tick_n(1);
    check("resume3.invuln", int'(invuln), 0);

    // Last life lost -> DEAD, then everything ignored
    hit_once(2'b01);
    chk_all("dead", 0, 0, 1, 1);
    hit = 2'b11; bonus_life = 1'b1; frame_tick = 1'b1;
    step(); step();
    hit = 2'b00; bonus_life = 1'b0; frame_tick = 1'b0;
    chk_all("dead_ign", 0, 0, 0, 1);

    // new_game while DEAD and frozen
    freeze_n = 1'b0; new_game = 1'b1;
    step();
    new_game = 1'b0; freeze_n = 1'b1;
    chk_all("newgame", 3, 0, 0, 0);

    // Simultaneous hits count once; three separated hits reach game over
    hit_once(2'b11);
    chk_all("dual_hit", 2, 1, 1, 0);
    tick_n(4);
    hit_once(2'b01);
    check("sep2.lives", int'(lives), 1);
    tick_n(4);
    hit_once(2'b10);
    chk_all("sep3", 0, 0, 1, 1);
    bonus_life = 1'b1;
    step();
    bonus_life = 1'b0;
    check("dead_bonus.lives", int'(lives), 0);

    // Bonus saturation from 3
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    bonus_life = 1'b1;
    step(); check("bonus1", int'(lives), 4);
    step(); check("bonus2", int'(lives), 5);
    step(); check("bonus3", int'(lives), 5);
    step(); check("bonus4", int'(lives), 5);
    bonus_life = 1'b0;

    // Frozen ALIVE: hit dropped, no pulse
    freeze_n = 1'b0;
    hit_once(2'b01);
    freeze_n = 1'b1;
    chk_all("frozen_alive", 5, 0, 0, 0);

    // Async reset mid-INVULN clears invuln without a clock edge
    hit_once(2'b01);
    chk_all("pre_rst", 4, 1, 1, 0);
    #2;
    resetN = 1'b0;
    #1;
    chk_all("async_rst", 3, 0, 0, 0);
    resetN = 1'b1;
    step();
    hit_once(2'b10);
    chk_all("post_rst_hit", 2, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
